aud_player: RTL and testbench
=============================

# aud_player

Audio playback engine for the lab3 audio path. It reads 16-bit PCM samples from SRAM through a simple address/data port and serializes them MSB-first onto the WM8731 DAC data line in I2S format. The same sample is sent on both channels (mono). It sits between the SRAM arbiter and the codec, and is controlled by the top-level FSM with start/pause/stop pulses.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, sample width; the bit counter must cover DATA_W.

Ports:
- i_clk  in  1  codec BCLK; all state updates on the falling edge.
- i_rst_n  in  1  reset i_rst_n, asynchronous, active-high.
- i_lrc  in  1  DACLRCK; low = left channel, high = right channel.
- i_start  in  1  one-cycle pulse; starts playback from address 0. Honoured only in IDLE.
- i_pause  in  1  one-cycle pulse; toggles pause/resume.
- i_stop  in  1  one-cycle pulse; aborts playback.
- i_end_addr  in  ADDR_W  address of the last valid sample.
- i_sram_data  in  DATA_W  SRAM read data for o_address; asynchronous read, valid 1 cycle after the address changes.
- o_address  out  ADDR_W  SRAM read address.
- o_dacdat  out  1  serial DAC data, registered.
- o_done  out  1  one-cycle pulse when playback ends.

## Operation
- lrc_d register samples i_lrc every edge in every state.
- Left start (L): lrc_d=1 and i_lrc=0. Right start (R): lrc_d=0 and i_lrc=1.
- States:
  - IDLE: i_start → address=0 → WAIT.
  - WAIT: o_dacdat=0. On L → PLAY, running the L actions below.
  - PLAY:
    - On L: sample_r ← i_sram_data; shift_r ← i_sram_data; cnt=0.
    - On R: shift_r ← sample_r; cnt=0. If address==i_end_addr → DRAIN; else address+1.
  - DRAIN: finish the right word. On the next L → FINISH.
  - PAUSE: o_dacdat=0; address, sample_r and cnt are held. i_pause → WAIT, which realigns to the next L.
  - FINISH: o_done=1, address=0 → IDLE.
- Priority within one edge: i_stop > i_pause > end-of-data > normal.
  - i_stop in WAIT, PLAY, PAUSE or DRAIN → FINISH.
  - i_pause in PLAY → PAUSE, with o_dacdat forced 0 from that edge on.
  - i_pause in WAIT or DRAIN is ignored.
- Pulses on i_start/i_pause/i_stop arriving in IDLE or FINISH are ignored, except i_start in IDLE.
- Address arithmetic is unsigned, ADDR_W bits. i_end_addr is sampled on each R edge; changing it mid-play takes effect at the next R.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The DAC sees silence.

## Timing
- Reset values: state IDLE, o_address=0, o_dacdat=0, o_done=0, sample_r=0, shift_r=0, cnt=0, lrc_d=0.
- Serialization:
  - On an L or R edge k, o_dacdat ← word[15].
  - Edges k+1..k+15 carry bits 14..0.
  - From edge k+16 until the next channel edge, o_dacdat=0.
  - cnt saturates at 16.
- Address increments on the R edge. The next sample is latched on the following L edge, at least 16 edges later, so SRAM latency is hidden.
- End of data: the last sample plays left and right. On the next L, FINISH is entered and o_done pulses one cycle later; the state is IDLE the cycle after that.
- i_stop to o_done: 1 edge for the state change, then o_done is high for exactly one cycle.

## Configuration
- AUD_PLAYER_LOOP_EN defined: on R with address==i_end_addr, address ← 0 and the block stays in PLAY. DRAIN is never entered and o_done only follows i_stop.
- AUD_PLAYER_LOOP_EN undefined: end-of-data behaviour as described under Operation. The DRAIN state exists only in this build.

## Test plan
- Reset: assert i_rst_n mid-PLAY → next edge o_address=0, o_dacdat=0, o_done=0. After release, no output until i_start.
- Basic play:
  - Stimulus: SRAM[0]=16'hA5C3, SRAM[1]=16'h0F0F, i_end_addr=1, i_start.
  - Required: after the first L, o_dacdat=1010010111000011 on left, then the same on right; o_address goes 0→1 on that R.
  - Next frame sends 0F0F twice, then o_done pulses once and o_address=0.
- Pause: i_pause at bit 5 of a left word → o_dacdat=0 from that edge and o_address held for 3 frames. Second i_pause → playback resumes at the next L with the same held address.
- Stop: i_stop during the right word of sample 3 → FINISH next edge, single o_done pulse, IDLE, o_address=0. Later i_pause pulses have no effect.
- Simultaneous events: i_stop and i_pause on the same edge → FINISH; i_start while in PLAY → ignored.
- With AUD_PLAYER_LOOP_EN and i_end_addr=2: o_address sequence 0,1,2,0,1,2… across R edges, o_done never asserted until i_stop.

Source files
------------

// File: rtl/aud_player.sv
// aud_player: reads 16-bit PCM samples from SRAM and plays them mono (same word left and right) as I2S on the WM8731 DAC line.
// All state moves on falling BCLK. Define AUD_PLAYER_LOOP_EN to wrap to address 0 at i_end_addr instead of ending playback.
module aud_player #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_dacdat,
  output logic              o_done
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
`ifndef AUD_PLAYER_LOOP_EN
  localparam logic [2:0] S_DRAIN  = 3'd3;
`endif
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state;
  logic              lrc_d;
  logic [DATA_W-1:0] sample_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt;
  logic              left_edge;
  logic              right_edge;
  logic              at_end;
  logic              ser_bit;

  assign left_edge  = lrc_d & ~i_lrc;
  assign right_edge = ~lrc_d & i_lrc;
  assign at_end     = (o_address == i_end_addr);
  // MSB went out on the channel edge; the next DATA_W-1 edges carry the rest, then silence
  assign ser_bit    = (cnt < CNT_LAST) ? shift_r[DATA_W-2] : 1'b0;

  always_ff @(negedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state     <= S_IDLE;
      lrc_d     <= 1'b0;
      sample_r  <= '0;
      shift_r   <= '0;
      cnt       <= '0;
      o_address <= '0;
      o_dacdat  <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      lrc_d  <= i_lrc;
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_dacdat <= 1'b0;
          if (i_start) begin
            o_address <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          o_dacdat <= 1'b0;
          if (i_stop) begin
            state <= S_FINISH;
          end else if (left_edge) begin
            state    <= S_PLAY;
            sample_r <= i_sram_data;
            shift_r  <= i_sram_data;
            cnt      <= '0;
            o_dacdat <= i_sram_data[DATA_W-1];
          end
        end
        S_PLAY: begin
          if (i_stop) begin
            state    <= S_FINISH;
            o_dacdat <= 1'b0;
          end else if (i_pause) begin
            state    <= S_PAUSE;
            o_dacdat <= 1'b0;
          end else if (left_edge) begin
            // address moved on the previous R edge, so SRAM data has long settled
            sample_r <= i_sram_data;
            shift_r  <= i_sram_data;
            cnt      <= '0;
            o_dacdat <= i_sram_data[DATA_W-1];
          end else if (right_edge) begin
            shift_r  <= sample_r;
            cnt      <= '0;
            o_dacdat <= sample_r[DATA_W-1];
            if (at_end) begin
`ifdef AUD_PLAYER_LOOP_EN
              o_address <= '0;
`else
              state <= S_DRAIN;
`endif
            end else begin
              o_address <= o_address + ADDR_W'(1);
            end
          end else begin
            o_dacdat <= ser_bit;
            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
        end
`ifndef AUD_PLAYER_LOOP_EN
        S_DRAIN: begin
          if (i_stop || left_edge) begin
            state    <= S_FINISH;
            o_dacdat <= 1'b0;
          end else begin
            o_dacdat <= ser_bit;
            shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_PAUSE: begin
          o_dacdat <= 1'b0;
          if (i_stop) begin
            state <= S_FINISH;
          end else if (i_pause) begin
            state <= S_WAIT;
          end
        end
        S_FINISH: begin
          o_dacdat  <= 1'b0;
          o_done    <= 1'b1;
          o_address <= '0;
          state     <= S_IDLE;
        end
        default: begin
          o_dacdat <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aud_player.sv
// Bench for aud_player: scenario table plus random runs, each checked edge by edge against a timeline model of the I2S stream.
module tb_aud_player;
  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int NONE = -100000;

  typedef struct {
    int end_a;
    int stop_t;
    int pause_t;
    int resume_t;
    int start_t;
    int exp_done_t;
  } scen_t;

  logic          i_clk, i_rst_n, i_lrc, i_start, i_pause, i_stop;
  logic [AW-1:0] i_end_addr, o_address;
  logic [DW-1:0] i_sram_data;
  logic          o_dacdat, o_done;

  logic [DW-1:0] mem [0:15];
  int            ph;
  int            checks;
  int            errors;

  aud_player #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_start(i_start),
    .i_pause(i_pause), .i_stop(i_stop), .i_end_addr(i_end_addr),
    .i_sram_data(i_sram_data), .o_address(o_address), .o_dacdat(o_dacdat),
    .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // SRAM: data follows the address one edge later
  always @(negedge i_clk) i_sram_data <= mem[o_address[3:0]];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One BCLK: lrc is a 64-edge frame (32 low = left, 32 high = right); outputs read at the rising edge.
  task automatic step(input logic st, input logic pa, input logic sp);
    i_start = st;
    i_pause = pa;
    i_stop  = sp;
    i_lrc   = (ph % 64) >= 32;
    @(negedge i_clk);
    ph++;
    @(posedge i_clk);
  endtask

  function automatic int min_set(input int a, input int c);
    if (a < 0) return c;
    if (c < 0) return a;
    return (a < c) ? a : c;
  endfunction

  task automatic run_play(input scen_t s, input string tag);
    int vs, gL, g, vg, t, b, n0, held, nat, fstop, f, rel, n, pos, half, done_cnt, first_done;
    logic sp, pa, st, paused, e_dac, e_done, loop_en;
    logic [AW-1:0] e_addr, prev_addr;
`ifdef AUD_PLAYER_LOOP_EN
    loop_en = 1'b1;
`else
    loop_en = 1'b0;
`endif
    i_end_addr = AW'(s.end_a);
    repeat ($urandom_range(2, 70)) step(0, 0, 0);
    check({tag, " idle"}, 32'({o_done, o_dacdat, o_address}), 32'd0);
    vs = ph % 64;
    step(1, 0, 0);
    gL = 64 - vs;   // first L edge strictly after the start edge
    b = gL; n0 = 0; held = 0; paused = 1'b0; fstop = -1;
    nat = loop_en ? -1 : gL + (s.end_a + 1) * 64;
    prev_addr = '0; done_cnt = 0; first_done = NONE;
    for (g = 1; g < 3000; g++) begin
      f = min_set(fstop, nat);
      if (f >= 0 && g > f + 80) break;
      t  = g - gL;
      sp = (t == s.stop_t);
      st = (t == s.start_t);
      pa = (t == s.pause_t) || (t == s.resume_t) || (f >= 0 && (g == f + 5 || g == f + 40));
      vg = ph % 64;
      step(st, pa, sp);
      if (f < 0 || g < f) begin
        if (sp) begin
          fstop = g;
        end else if (pa && paused) begin
          paused = 1'b0;
          n0  = held;
          b   = g + 64 - vg;
          nat = loop_en ? -1 : b + (s.end_a + 1 - n0) * 64;
        end else if (pa && g >= b && (loop_en || g - b <= (s.end_a + 1 - n0) * 64 - 32)) begin
          paused = 1'b1;
          held   = int'(prev_addr);
          nat    = -1;
        end
      end
      f = min_set(fstop, nat);
      e_done = 1'b0;
      e_dac  = 1'b0;
      if (f >= 0 && g > f + 1) e_addr = '0;
      else if (f >= 0 && g == f + 1) begin
        e_done = 1'b1;
        e_addr = '0;
      end else if (f >= 0 && g == f) e_addr = prev_addr;
      else if (paused) e_addr = AW'(held);
      else if (g < b) e_addr = AW'(n0);
      else begin
        rel  = g - b;
        pos  = rel % 64;
        half = pos % 32;
        n    = n0 + rel / 64;
        if (loop_en) n = n % (s.end_a + 1);
        e_dac = (half < 16) ? mem[n][15-half] : 1'b0;
        if (pos < 32) e_addr = AW'(n);
        else if (n == s.end_a) e_addr = loop_en ? '0 : AW'(n);
        else e_addr = AW'(n + 1);
      end
      check($sformatf("%s t=%0d {done,dac,addr}", tag, t),
            32'({o_done, o_dacdat, o_address}), 32'({e_done, e_dac, e_addr}));
      if (o_done === 1'b1) begin
        done_cnt++;
        if (first_done == NONE) first_done = t;
      end
      prev_addr = e_addr;
    end
    if (s.exp_done_t != NONE) begin
      check({tag, " done time"}, 32'(first_done), 32'(s.exp_done_t));
      check({tag, " done count"}, 32'(done_cnt), 32'd1);
    end
  endtask

  initial begin
    scen_t tbl[$];
    scen_t rs;
    int e;
    checks = 0; errors = 0; ph = 0;
    i_rst_n = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0; i_lrc = 1'b0;
    i_end_addr = '0;
    for (int k = 0; k < 16; k++) mem[k] = 16'(k);

    // {end, stop_t, pause_t, resume_t, start_t, done_t}; times in edges from the first L edge
`ifdef AUD_PLAYER_LOOP_EN
    tbl.push_back('{2, 500, NONE, NONE, NONE, 501});
    tbl.push_back('{0, 400, 70, 200, NONE, 401});
    tbl.push_back('{3, 300, NONE, NONE, 100, 301});
`else
    tbl.push_back('{1, NONE, NONE, NONE, NONE, 129});
    tbl.push_back('{0, NONE, NONE, NONE, NONE, 65});
    tbl.push_back('{5, 232, NONE, NONE, NONE, 233});
    tbl.push_back('{4, 100, 100, NONE, NONE, 101});
    tbl.push_back('{2, NONE, NONE, NONE, 70, 193});
    tbl.push_back('{2, NONE, 69, 261, NONE, 449});
    tbl.push_back('{3, NONE, 104, 296, NONE, 449});
    tbl.push_back('{3, 150, 20, NONE, NONE, 151});
    tbl.push_back('{1, NONE, 96, 200, NONE, 321});
    tbl.push_back('{1, NONE, 110, NONE, NONE, 129});
`endif

    repeat (4) step(0, 0, 0);
    check("reset state", 32'({o_done, o_dacdat, o_address}), 32'd0);
    i_rst_n = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
      if (i == 0) begin
        mem[0] = 16'hA5C3;
        mem[1] = 16'h0F0F;
      end
      run_play(tbl[i], $sformatf("row%0d", i));
    end

    // asynchronous reset in the middle of playback
    for (int k = 0; k < 16; k++) mem[k] = 16'($urandom) | 16'h8000;
    i_end_addr = AW'(5);
    step(1, 0, 0);
    repeat (150) step(0, 0, 0);
    check("pre-reset busy", 32'(o_address != '0), 32'd1);
    #1 i_rst_n = 1'b1;
    #1 check("reset async", 32'({o_done, o_dacdat, o_address}), 32'd0);
    step(0, 0, 0);
    check("reset held", 32'({o_done, o_dacdat, o_address}), 32'd0);
    i_rst_n = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step(0, k[0], k[1] & k[2]);
      if (k % 8 == 0)
        check($sformatf("post-reset quiet %0d", k), 32'({o_done, o_dacdat, o_address}), 32'd0);
    end

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
      e = int'($urandom_range(0, 5));
      rs = '{e, NONE, NONE, NONE, NONE, NONE};
      if ($urandom_range(0, 1) == 1) begin
        rs.pause_t  = int'($urandom_range(1, (e + 1) * 64 - 1));
        rs.resume_t = rs.pause_t + int'($urandom_range(1, 200));
      end
`ifdef AUD_PLAYER_LOOP_EN
      rs.stop_t = int'($urandom_range(1, 600));
`else
      if ($urandom_range(0, 1) == 1) rs.stop_t = int'($urandom_range(1, (e + 1) * 64 - 1));
`endif
      if (rs.stop_t == NONE && rs.pause_t == NONE)
        rs.start_t = int'($urandom_range(1, (e + 1) * 64 - 1));
      run_play(rs, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
